// File: rtl/error_injection_scheduler.sv
// Sequences the error injector through DELAY/WINDOW/GAP bursts and totals flipped bits; `ERR_SCHED_TRIGGER_EN adds fc_trigger.
// Latency: start sampled -> inj_reset next cycle; all outputs registered off the next-state decode.
// Backpressure: counting states advance only on beat; cycles without beat hold state and counts.
module error_injection_scheduler #(
  parameter int WIDTH       = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic [CNT_WIDTH-1:0]   cfg_delay,
  input  logic [CNT_WIDTH-1:0]   cfg_window,
  input  logic [CNT_WIDTH-1:0]   cfg_gap,
  input  logic [BURST_WIDTH-1:0] cfg_bursts,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   beat,
  input  logic [WIDTH-1:0]       error_bits,
`ifdef ERR_SCHED_TRIGGER_EN
  input  logic                   fc_trigger,
`endif
  output logic                   inj_enable,
  output logic                   inj_reset,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] burst_index,
  output logic [CNT_WIDTH-1:0]   error_count
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_DELAY, S_WINDOW, S_GAP, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   sh_delay, sh_window, sh_gap;
  logic [BURST_WIDTH-1:0] sh_bursts;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0]   win_len;
  logic                   trig;
  logic                   accept;
  logic                   go_delay, go_window, win_exit, gap_exit;
  logic [PW-1:0]          pop;
  logic [SW-1:0]          err_sum;
  logic [CNT_WIDTH-1:0]   err_next;

`ifdef ERR_SCHED_TRIGGER_EN
  assign trig = fc_trigger;
`else
  assign trig = 1'b0;
`endif

  // A zero window with a zero gap would let a burst take no time; hold WINDOW one beat instead.
  assign win_len = (sh_window != '0) ? sh_window : CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    accept    = 1'b0;
    go_delay  = 1'b0;
    go_window = 1'b0;
    win_exit  = 1'b0;
    gap_exit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((start || trig) && !stop) begin
          accept  = 1'b1;
          state_d = S_ARM;
          burst_d = '0;
        end
      end
      S_ARM: go_delay = 1'b1;
      S_DELAY: begin
        if (beat) begin
          if (cnt_q == CNT_WIDTH'(1)) go_window = 1'b1;
          else                        cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_WINDOW: begin
        if (beat) begin
          if (cnt_q == CNT_WIDTH'(1)) win_exit = 1'b1;
          else                        cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (trig || (beat && cnt_q == CNT_WIDTH'(1))) gap_exit = 1'b1;
        else if (beat)                                 cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Zero-length states fall through in the same evaluation, in burst order.
    if (go_delay) begin
      if (sh_delay != '0) begin
        state_d = S_DELAY;
        cnt_d   = sh_delay;
      end else begin
        go_window = 1'b1;
      end
    end
    if (gap_exit) begin
      burst_d   = burst_d + BURST_WIDTH'(1);
      go_window = 1'b1;
    end
    if (go_window) begin
      if (sh_window != '0 || sh_gap == '0) begin
        state_d = S_WINDOW;
        cnt_d   = win_len;
      end else begin
        win_exit = 1'b1;
      end
    end
    if (win_exit) begin
      if (sh_bursts != '0 && burst_d == sh_bursts - BURST_WIDTH'(1)) begin
        state_d = S_DONE;
      end else if (sh_gap != '0) begin
        state_d = S_GAP;
        cnt_d   = sh_gap;
      end else begin
        burst_d = burst_d + BURST_WIDTH'(1);
        state_d = S_WINDOW;
        cnt_d   = win_len;
      end
    end

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      burst_d = burst_q;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(error_bits[i]);
  end

  assign err_sum  = SW'(error_count) + SW'(pop);
  assign err_next = (err_sum[SW-1:CNT_WIDTH] != '0) ? '1 : err_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      burst_q     <= '0;
      sh_delay    <= '0;
      sh_window   <= '0;
      sh_gap      <= '0;
      sh_bursts   <= '0;
      inj_enable  <= 1'b0;
      inj_reset   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      inj_enable <= (state_d == S_WINDOW) && (sh_window != '0);
      inj_reset  <= (state_d == S_ARM);
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_DONE);
      if (accept) begin
        sh_delay    <= cfg_delay;
        sh_window   <= cfg_window;
        sh_gap      <= cfg_gap;
        sh_bursts   <= cfg_bursts;
        error_count <= '0;
      end else if (busy && beat) begin
        error_count <= err_next;
      end
    end
  end

  assign burst_index = burst_q;

endmodule

// File: tb/tb_error_injection_scheduler.sv
// Directed bench for error_injection_scheduler: burst timing, beat stalls, stop, zero lengths,
// infinite runs, error_count clear/hold/saturation and async reset.
module tb_error_injection_scheduler;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_delay, cfg_window, cfg_gap;
  logic [15:0] cfg_bursts;
  logic        start, stop, beat;
  logic [31:0] error_bits;
  logic        inj_enable, inj_reset, busy, done;
  logic [15:0] burst_index;
  logic [31:0] error_count;
`ifdef ERR_SCHED_TRIGGER_EN
  logic        fc_trigger = 1'b0;
  logic        d2_trigger = 1'b0;
`endif

  logic [7:0]  d2_delay, d2_window, d2_gap;
  logic [3:0]  d2_bursts;
  logic        d2_start, d2_stop, d2_beat;
  logic [15:0] d2_bits;
  logic        d2_en, d2_rst, d2_busy, d2_done;
  logic [3:0]  d2_index;
  logic [7:0]  d2_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  error_injection_scheduler dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_delay(cfg_delay), .cfg_window(cfg_window), .cfg_gap(cfg_gap), .cfg_bursts(cfg_bursts),
    .start(start), .stop(stop), .beat(beat), .error_bits(error_bits),
`ifdef ERR_SCHED_TRIGGER_EN
    .fc_trigger(fc_trigger),
`endif
    .inj_enable(inj_enable), .inj_reset(inj_reset), .busy(busy), .done(done),
    .burst_index(burst_index), .error_count(error_count)
  );

  error_injection_scheduler #(.WIDTH(16), .CNT_WIDTH(8), .BURST_WIDTH(4)) dut_sat (
    .clk(clk), .aresetn(aresetn),
    .cfg_delay(d2_delay), .cfg_window(d2_window), .cfg_gap(d2_gap), .cfg_bursts(d2_bursts),
    .start(d2_start), .stop(d2_stop), .beat(d2_beat), .error_bits(d2_bits),
`ifdef ERR_SCHED_TRIGGER_EN
    .fc_trigger(d2_trigger),
`endif
    .inj_enable(d2_en), .inj_reset(d2_rst), .busy(d2_busy), .done(d2_done),
    .burst_index(d2_index), .error_count(d2_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge of cycle 1 (the ARM cycle).
  task automatic launch(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                        input logic [15:0] b);
    cfg_delay  = d;
    cfg_window = w;
    cfg_gap    = g;
    cfg_bursts = b;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_delay = '0; cfg_window = '0; cfg_gap = '0; cfg_bursts = '0;
    start = 1'b0; stop = 1'b0; beat = 1'b1; error_bits = '0;
    d2_delay = 8'd100; d2_window = 8'd1; d2_gap = 8'd1; d2_bursts = '0;
    d2_start = 1'b0; d2_stop = 1'b0; d2_beat = 1'b1; d2_bits = 16'h03FF;
    repeat (2) @(negedge clk);
    check("rst_en", inj_enable, 0);
    check("rst_inj_reset", inj_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", burst_index, 0);
    check("rst_count", error_count, 0);
    aresetn = 1'b1;
    @(negedge clk);

    // Two bursts, beat every cycle; 0x101 on the first four busy beats
    launch(3, 4, 2, 2);
    for (int c = 1; c <= 16; c++) begin
      error_bits = (c <= 4) ? 32'h0000_0101 : 32'h0;
      check($sformatf("t1_en@%0d", c), inj_enable, (c >= 5 && c <= 8) || (c >= 11 && c <= 14));
      check($sformatf("t1_inj_reset@%0d", c), inj_reset, c == 1);
      check($sformatf("t1_done@%0d", c), done, c == 15);
      check($sformatf("t1_busy@%0d", c), busy, c <= 15);
      @(negedge clk);
    end
    check("t1_count", error_count, 8);
    check("t1_index", burst_index, 1);

    // Same config with beat on even cycles only: windows stretch to 8 clocks
    launch(3, 4, 2, 2);
    for (int c = 1; c <= 28; c++) begin
      beat = (c % 2 == 0);
      check($sformatf("t2_en@%0d", c), inj_enable, (c >= 7 && c <= 14) || (c >= 19 && c <= 26));
      check($sformatf("t2_done@%0d", c), done, c == 27);
      check($sformatf("t2_busy@%0d", c), busy, c <= 27);
      @(negedge clk);
    end
    beat = 1'b1;
    check("t2_count_cleared", error_count, 0);

    // Stop on the second WINDOW cycle; popcount 3 on every busy beat
    error_bits = 32'h7;
    launch(3, 4, 2, 2);
    for (int c = 1; c <= 10; c++) begin
      stop = (c == 6);
      check($sformatf("t3_en@%0d", c), inj_enable, c == 5 || c == 6);
      check($sformatf("t3_busy@%0d", c), busy, c <= 6);
      check($sformatf("t3_done@%0d", c), done, 0);
      @(negedge clk);
    end
    stop = 1'b0;
    check("t3_count_held", error_count, 18);
    check("t3_index", burst_index, 0);
    error_bits = '0;

    // Zero window, nonzero bursts: no injection, still completes
    launch(1, 0, 2, 2);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("t4_en@%0d", c), inj_enable, 0);
      check($sformatf("t4_done@%0d", c), done, c == 5);
      check($sformatf("t4_busy@%0d", c), busy, c <= 5);
      @(negedge clk);
    end
    check("t4_index", burst_index, 1);

    // All-zero lengths with infinite bursts: one forced WINDOW cycle per burst
    launch(0, 0, 0, 0);
    for (int c = 1; c < 11; c++) @(negedge clk);
    check("t5_index", burst_index, 9);
    check("t5_busy", busy, 1);
    check("t5_en", inj_enable, 0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_busy", busy, 0);
    check("t5_stop_index", burst_index, 9);

    // Infinite run, window=1 gap=1, 100 beats; start mid-run is ignored
    launch(0, 1, 1, 0);
    for (int c = 1; c <= 101; c++) begin
      start = (c == 50);
      if (c == 100) check("t6_en@100", inj_enable, 1);
      if (c == 101) begin
        check("t6_index", burst_index, 49);
        check("t6_busy", busy, 1);
        check("t6_en@101", inj_enable, 0);
        stop = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    check("t6_stop_busy", busy, 0);

    // Start and stop together while idle: nothing starts
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check("t7_busy", busy, 0);
    check("t7_inj_reset", inj_reset, 0);

    // 8-bit counter saturation: popcount 10 per beat
    d2_start = 1'b1;
    @(negedge clk);
    d2_start = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if (c == 26) check("t8_count_250", d2_count, 250);
      if (c == 27) check("t8_count_sat", d2_count, 255);
      if (c == 28) check("t8_count_hold", d2_count, 255);
      @(negedge clk);
    end
    d2_stop = 1'b1;
    @(negedge clk);
    d2_stop = 1'b0;
    check("t8_busy", d2_busy, 0);

    // Async reset mid-window
    error_bits = 32'h7;
    launch(3, 4, 2, 2);
    for (int c = 1; c < 6; c++) @(negedge clk);
    check("t9_en_before", inj_enable, 1);
    #2 aresetn = 1'b0;
    #1;
    check("t9_en", inj_enable, 0);
    check("t9_busy", busy, 0);
    check("t9_done", done, 0);
    check("t9_count", error_count, 0);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("t9_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
